// File: rtl/sift_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | sift_pkg : shared types and sizing for the orientation histogram.    |
// | Optional macro: MAG_WEIGHT_EN (widens counters for magnitude adds).  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sift_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FIND  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int NUM_BINS = 8;

  typedef logic [2:0] bin_t;

`ifdef MAG_WEIGHT_EN
  localparam bit c_MAG_WEIGHT = 1'b1;
`else
  localparam bit c_MAG_WEIGHT = 1'b0;
`endif

  // Counter must hold a full window of unit hits, or of worst-case magnitudes.
  function automatic int cnt_w(input int radius, input int bit_depth);
    int side;
    side = 2 * radius + 1;
    return $clog2(side * side + 1) + (c_MAG_WEIGHT ? bit_depth + 1 : 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/orientation_histogram_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | orientation_histogram_if : request, gradient-BRAM and result bus.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface orientation_histogram_if #(
  parameter int WIDTH     = 64,
  parameter int HEIGHT    = 64,
  parameter int BIT_DEPTH = 8,
  parameter int CNT_W     = 5
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int AW = $clog2(WIDTH * HEIGHT);

  logic [XW-1:0]         center_x_in;
  logic [YW-1:0]         center_y_in;
  logic                  valid_in;
  logic                  ready_out;
  logic [AW-1:0]         x_read_addr;
  logic                  x_read_addr_valid;
  logic [BIT_DEPTH-1:0]  x_pixel_in;
  logic [AW-1:0]         y_read_addr;
  logic                  y_read_addr_valid;
  logic [BIT_DEPTH-1:0]  y_pixel_in;
  logic                  valid_out;
  logic [8*CNT_W-1:0]    histogram_out;
  logic [2:0]            dominant_bin_out;
  logic [CNT_W-1:0]      dominant_count_out;
  logic [2:0]            state_num;

  modport slave (
    input  center_x_in, center_y_in, valid_in, x_pixel_in, y_pixel_in,
    output ready_out, x_read_addr, x_read_addr_valid, y_read_addr,
           y_read_addr_valid, valid_out, histogram_out, dominant_bin_out,
           dominant_count_out, state_num
  );

  modport master (
    output center_x_in, center_y_in, valid_in, x_pixel_in, y_pixel_in,
    input  ready_out, x_read_addr, x_read_addr_valid, y_read_addr,
           y_read_addr_valid, valid_out, histogram_out, dominant_bin_out,
           dominant_count_out, state_num
  );
endinterface
`default_nettype wire

// File: rtl/orientation_histogram_octant_classifier.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | octant_classifier : maps a signed gradient pair to one of 8 octants. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module octant_classifier
  import sift_pkg::*;
#(
  parameter int BIT_DEPTH = 8
) (
  input  logic [BIT_DEPTH-1:0] gx,
  input  logic [BIT_DEPTH-1:0] gy,
  output bin_t                 bin,
  output logic                 zero,
  output logic [BIT_DEPTH:0]   mag
);
  logic [BIT_DEPTH-1:0] w_ax;
  logic [BIT_DEPTH-1:0] w_ay;
  logic                 w_ge;

  // Unsigned magnitude, so the most negative code maps to 2^(B-1).
  assign w_ax = gx[BIT_DEPTH-1] ? (~gx + BIT_DEPTH'(1)) : gx;
  assign w_ay = gy[BIT_DEPTH-1] ? (~gy + BIT_DEPTH'(1)) : gy;
  assign w_ge = (w_ax >= w_ay);

  assign zero = (gx == '0) && (gy == '0);
  assign mag  = {1'b0, w_ax} + {1'b0, w_ay};

  always_comb begin
    bin = 3'd0;
    case ({gx[BIT_DEPTH-1], gy[BIT_DEPTH-1]})
      2'b00:   bin = w_ge ? 3'd0 : 3'd1;
      2'b10:   bin = w_ge ? 3'd3 : 3'd2;
      2'b11:   bin = w_ge ? 3'd4 : 3'd5;
      default: bin = w_ge ? 3'd7 : 3'd6;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/orientation_histogram.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | orientation_histogram : windowed gradient scan into 8 octant bins.   |
// | Optional macro: MAG_WEIGHT_EN (add |gx|+|gy| instead of 1). Rev 1.0  |
// +----------------------------------------------------------------------+
module orientation_histogram
  import sift_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int HEIGHT    = 64,
  parameter int BIT_DEPTH = 8,
  parameter int RADIUS    = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  orientation_histogram_if.slave bus
);
  localparam int CNT_W = cnt_w(RADIUS, BIT_DEPTH);
  localparam int XW    = $clog2(WIDTH);
  localparam int YW    = $clog2(HEIGHT);
  localparam int AW    = $clog2(WIDTH * HEIGHT);
  localparam int OFF_W = $clog2(RADIUS + 1) + 1;
  localparam logic signed [OFF_W-1:0] c_POS_R   = OFF_W'(RADIUS);
  localparam logic signed [OFF_W-1:0] c_NEG_R   = -c_POS_R;
  localparam logic signed [OFF_W-1:0] c_ONE     = OFF_W'(1);
  localparam logic [CNT_W-1:0]        c_CNT_MAX = '1;

  state_t                  r_state, w_next;
  logic [XW-1:0]           r_cx;
  logic [YW-1:0]           r_cy;
  logic signed [OFF_W-1:0] r_col, r_row;
  logic [2:0]              r_step;
  logic [1:0]              r_tag;
  logic [CNT_W-1:0]        r_hist [NUM_BINS];
  bin_t                    r_max_bin, r_dom_bin;
  logic [CNT_W-1:0]        r_max_cnt, r_dom_cnt;

  logic                    w_accept, w_scan_last, w_in_bounds;
  logic signed [31:0]      w_x, w_y;
  logic                    w_rd_valid;
  logic [AW-1:0]           w_rd_addr;
  bin_t                    w_bin, w_find_bin;
  logic                    w_zero, w_take;
  logic [BIT_DEPTH:0]      w_mag;
  logic [CNT_W-1:0]        w_inc, w_sum_sat, w_find_val, w_find_cnt;
  logic [CNT_W:0]          w_sum;
  logic [8*CNT_W-1:0]      w_hist_flat;

  assign w_accept    = (r_state == ST_IDLE) && bus.valid_in;
  assign w_x         = $signed({{(32-XW){1'b0}}, r_cx}) + $signed({{(32-OFF_W){r_col[OFF_W-1]}}, r_col});
  assign w_y         = $signed({{(32-YW){1'b0}}, r_cy}) + $signed({{(32-OFF_W){r_row[OFF_W-1]}}, r_row});
  assign w_in_bounds = (w_x >= 0) && (w_x < WIDTH) && (w_y >= 0) && (w_y < HEIGHT);
  assign w_scan_last = (r_col == c_POS_R) && (r_row == c_POS_R);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= ST_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.valid_in)      w_next = ST_SCAN;
      ST_SCAN:  if (w_scan_last)       w_next = ST_DRAIN;
      ST_DRAIN: if (r_step == 3'd1)    w_next = ST_FIND;
      ST_FIND:  if (r_step == 3'd7)    w_next = ST_DONE;
      ST_DONE:                         w_next = ST_IDLE;
      default:                         w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rd_valid = 1'b0;
    w_rd_addr  = '0;
    if ((r_state == ST_SCAN) && w_in_bounds) begin
      w_rd_valid = 1'b1;
      w_rd_addr  = AW'(w_y * WIDTH + w_x);
    end
  end

  assign bus.ready_out          = (r_state == ST_IDLE);
  assign bus.valid_out          = (r_state == ST_DONE);
  assign bus.x_read_addr        = w_rd_addr;
  assign bus.y_read_addr        = w_rd_addr;
  assign bus.x_read_addr_valid  = w_rd_valid;
  assign bus.y_read_addr_valid  = w_rd_valid;
  assign bus.state_num          = r_state;
  assign bus.histogram_out      = w_hist_flat;
  assign bus.dominant_bin_out   = r_dom_bin;
  assign bus.dominant_count_out = r_dom_cnt;

  for (genvar k = 0; k < NUM_BINS; k++) begin : g_pack
    assign w_hist_flat[k*CNT_W +: CNT_W] = r_hist[k];
  end

  octant_classifier #(.BIT_DEPTH(BIT_DEPTH)) u_classifier (
    .gx   (bus.x_pixel_in),
    .gy   (bus.y_pixel_in),
    .bin  (w_bin),
    .zero (w_zero),
    .mag  (w_mag)
  );

`ifdef MAG_WEIGHT_EN
  assign w_inc = CNT_W'(w_mag);
`else
  // Unit weight for any pixel that carries an orientation.
  assign w_inc = CNT_W'(w_mag != '0);
`endif

  assign w_sum      = {1'b0, r_hist[w_bin]} + {1'b0, w_inc};
  assign w_sum_sat  = w_sum[CNT_W] ? c_CNT_MAX : w_sum[CNT_W-1:0];
  assign w_find_val = r_hist[r_step];
  assign w_take     = (w_find_val > r_max_cnt);
  assign w_find_bin = w_take ? bin_t'(r_step) : r_max_bin;
  assign w_find_cnt = w_take ? w_find_val : r_max_cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cx <= '0;  r_cy <= '0;  r_col <= '0;  r_row <= '0;
      r_step <= '0;  r_tag <= '0;
    end else begin
      r_tag  <= {r_tag[0], w_rd_valid};
      r_step <= (w_next != r_state) ? 3'd0 : r_step + 3'd1;
      if (w_accept) begin
        r_cx  <= bus.center_x_in;
        r_cy  <= bus.center_y_in;
        r_col <= c_NEG_R;
        r_row <= c_NEG_R;
      end else if (r_state == ST_SCAN) begin
        if (r_col == c_POS_R) begin
          r_col <= c_NEG_R;
          r_row <= r_row + c_ONE;
        end else begin
          r_col <= r_col + c_ONE;
        end
      end
    end
  end

  // Returning data is tagged by the 2-deep strobe pipe; untagged cycles are ignored.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_BINS; i++) r_hist[i] <= '0;
      r_max_bin <= '0;  r_max_cnt <= '0;  r_dom_bin <= '0;  r_dom_cnt <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < NUM_BINS; i++) r_hist[i] <= '0;
      r_max_bin <= '0;  r_max_cnt <= '0;  r_dom_bin <= '0;  r_dom_cnt <= '0;
    end else begin
      if (r_tag[1] && !w_zero) r_hist[w_bin] <= w_sum_sat;
      if (r_state == ST_FIND) begin
        r_max_bin <= w_find_bin;
        r_max_cnt <= w_find_cnt;
        if (r_step == 3'd7) begin
          r_dom_bin <= w_find_bin;
          r_dom_cnt <= w_find_cnt;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_orientation_histogram.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_orientation_histogram : vector table, corner sequences, random.   |
// | Honours MAG_WEIGHT_EN when defined. Revision: 1.0                    |
// +----------------------------------------------------------------------+
module tb_orientation_histogram;
  import sift_pkg::*;

  localparam int WIDTH  = 64;
  localparam int HEIGHT = 64;
  localparam int BD     = 8;
  localparam int RADIUS = 2;
  localparam int CNT_W  = cnt_w(RADIUS, BD);
  localparam int NPIX   = WIDTH * HEIGHT;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  orientation_histogram_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .BIT_DEPTH(BD), .CNT_W(CNT_W)) bus ();

  orientation_histogram #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .BIT_DEPTH(BD), .RADIUS(RADIUS)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  int gx_mem [NPIX];
  int gy_mem [NPIX];
  logic [BD-1:0] s1x, s1y, s2x, s2y;
  logic          cap_v;
  logic [11:0]   cap_a;
  int rd_total = 0;
  int bus_err  = 0;

  // Two-cycle-latency gradient BRAMs; unread cycles return noise.
  always @(negedge clk_in) begin
    cap_v = bus.x_read_addr_valid;
    cap_a = bus.x_read_addr;
    if (cap_v === 1'b1) rd_total++;
    if (bus.y_read_addr_valid !== bus.x_read_addr_valid ||
        (cap_v === 1'b1 && bus.y_read_addr !== bus.x_read_addr)) bus_err++;
  end
  always @(posedge clk_in) begin
    s1x <= (cap_v === 1'b1) ? BD'(gx_mem[cap_a]) : BD'($urandom);
    s1y <= (cap_v === 1'b1) ? BD'(gy_mem[cap_a]) : BD'($urandom);
    s2x <= s1x;
    s2y <= s1y;
  end
  assign bus.x_pixel_in = s2x;
  assign bus.y_pixel_in = s2y;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int classify(input int gx, input int gy);
    int ax, ay;
    ax = iabs(gx);
    ay = iabs(gy);
    if (gx == 0 && gy == 0) return -1;
    if (gx >= 0 && gy >= 0) return (ax >= ay) ? 0 : 1;
    if (gx <  0 && gy >= 0) return (ay >  ax) ? 2 : 3;
    if (gx <  0 && gy <  0) return (ax >= ay) ? 4 : 5;
    return (ay > ax) ? 6 : 7;
  endfunction

  function automatic int weight(input int gx, input int gy);
`ifdef MAG_WEIGHT_EN
    return iabs(gx) + iabs(gy);
`else
    return (gx == 0 && gy == 0) ? 0 : 1;
`endif
  endfunction

  int e_hist [8];
  int e_reads, e_bin, e_cnt;

  task automatic model(input int cx, input int cy);
    int cmax, x, y, a, b;
    cmax = (1 << CNT_W) - 1;
    for (int i = 0; i < 8; i++) e_hist[i] = 0;
    e_reads = 0;
    for (int dy = -RADIUS; dy <= RADIUS; dy++)
      for (int dx = -RADIUS; dx <= RADIUS; dx++) begin
        x = cx + dx;
        y = cy + dy;
        if (x >= 0 && x < WIDTH && y >= 0 && y < HEIGHT) begin
          e_reads++;
          a = y * WIDTH + x;
          b = classify(gx_mem[a], gy_mem[a]);
          if (b >= 0) begin
            e_hist[b] += weight(gx_mem[a], gy_mem[a]);
            if (e_hist[b] > cmax) e_hist[b] = cmax;
          end
        end
      end
    e_bin = 0;
    e_cnt = 0;
    for (int i = 0; i < 8; i++)
      if (e_hist[i] > e_cnt) begin e_bin = i; e_cnt = e_hist[i]; end
  endtask

  task automatic fill(input int gx, input int gy);
    for (int i = 0; i < NPIX; i++) begin gx_mem[i] = gx; gy_mem[i] = gy; end
  endtask

  task automatic put(input int x, input int y, input int gx, input int gy);
    gx_mem[y * WIDTH + x] = gx;
    gy_mem[y * WIDTH + x] = gy;
  endtask

  function automatic int hist_bin(input int k);
    return int'(bus.histogram_out[k*CNT_W +: CNT_W]);
  endfunction

  // Issue one request and compare the whole result against the model.
  task automatic run(input int cx, input int cy, input string tag);
    int start_rd, start_err, lat;
    bit seen;
    model(cx, cy);
    @(negedge clk_in);
    check({tag, " ready"}, bus.ready_out, 1);
    bus.center_x_in = 6'(cx);
    bus.center_y_in = 6'(cy);
    bus.valid_in    = 1'b1;
    start_rd  = rd_total;
    start_err = bus_err;
    seen = 1'b0;
    for (lat = 1; lat <= 100; lat++) begin
      @(negedge clk_in);
      bus.valid_in = 1'b0;
      if (bus.valid_out === 1'b1) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      check({tag, " valid_out timeout"}, 0, 1);
      return;
    end
    check({tag, " latency"}, lat, 36);
    check({tag, " reads"}, rd_total - start_rd, e_reads);
    check({tag, " y bus tracks x"}, bus_err - start_err, 0);
    check({tag, " state DONE"}, bus.state_num, 4);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s bin%0d", tag, k), hist_bin(k), e_hist[k]);
    check({tag, " dom bin"}, bus.dominant_bin_out, e_bin);
    check({tag, " dom cnt"}, bus.dominant_count_out, e_cnt);
    @(negedge clk_in);
    check({tag, " valid pulse width"}, bus.valid_out, 0);
  endtask

  typedef struct {
    int cx; int cy; int gx; int gy; int bin; int pix; int reads;
  } vec_t;
  vec_t tbl [8];

  int sw_gx [8] = '{4, 3, -3, -4, -4, -3, 3, 4};
  int sw_gy [8] = '{4, 9, 9, 4, -4, -9, -9, -4};
  int sb_gx [8] = '{127, 3, -3, -128, -4, -3, 3, 127};
  int sb_gy [8] = '{0, 9, 9, 0, -4, -9, -9, -127};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt, cx, cy;
    bus.valid_in    = 1'b0;
    bus.center_x_in = '0;
    bus.center_y_in = '0;
    fill(0, 0);

    tbl[0] = '{32, 32,   10,   3, 0, 25, 25};
    tbl[1] = '{ 0,  0,   -5,   9, 2,  9,  9};
    tbl[2] = '{63, 63,   -3,  -7, 5,  9,  9};
    tbl[3] = '{63,  0,    7,  -2, 7,  9,  9};
    tbl[4] = '{ 1, 62,    0,   0, 0,  0, 16};
    tbl[5] = '{32, 32,   -3,  -7, 5, 25, 25};
    tbl[6] = '{ 2, 40,   -6,  -6, 4, 25, 25};
    tbl[7] = '{10, 61, -128,   0, 3, 25, 25};

    repeat (3) @(negedge clk_in);
    check("reset ready", bus.ready_out, 1);
    check("reset valid_out", bus.valid_out, 0);
    check("reset state", bus.state_num, 0);
    check("reset histogram", bus.histogram_out, 0);
    check("reset dom bin", bus.dominant_bin_out, 0);
    check("reset dom cnt", bus.dominant_count_out, 0);
    check("reset strobe", bus.x_read_addr_valid, 0);
    rst_n_in = 1'b1;

    for (int i = 0; i < 8; i++) begin
      fill(tbl[i].gx, tbl[i].gy);
      run(tbl[i].cx, tbl[i].cy, $sformatf("vec%0d", i));
      check($sformatf("vec%0d table bin", i), bus.dominant_bin_out, tbl[i].bin);
      check($sformatf("vec%0d table cnt", i), bus.dominant_count_out,
            tbl[i].pix * weight(tbl[i].gx, tbl[i].gy));
      check($sformatf("vec%0d table reads", i), e_reads, tbl[i].reads);
    end

    // One pixel per octant, zeros elsewhere.
    fill(0, 0);
    for (int p = 0; p < 8; p++) put(8 + p % 5, 8 + p / 5, sw_gx[p], sw_gy[p]);
    run(10, 10, "sweep");
    for (int k = 0; k < 8; k++)
      check($sformatf("sweep hand bin%0d", k), hist_bin(k), weight(sw_gx[k], sw_gy[k]));

    // Bins 3 and 6 tie; lowest index wins.
    fill(0, 0);
    for (int p = 0; p < 13; p++) begin
      if (p < 5)       put(18 + p % 5, 18 + p / 5, -4, 4);
      else if (p < 10) put(18 + p % 5, 18 + p / 5, 2, -6);
      else             put(18 + p % 5, 18 + p / 5, 4, 4);
    end
    run(20, 20, "tie");
    check("tie hand dom bin", bus.dominant_bin_out, 3);
    check("tie hand dom cnt", bus.dominant_count_out, 5 * weight(-4, 4));

    // Abort mid-scan with reset, then a fresh request.
    fill(10, 3);
    @(negedge clk_in);
    bus.center_x_in = 6'd32;
    bus.center_y_in = 6'd32;
    bus.valid_in    = 1'b1;
    @(negedge clk_in);
    bus.valid_in = 1'b0;
    repeat (9) @(negedge clk_in);
    check("abort pre state", bus.state_num, 1);
    #2 rst_n_in = 1'b0;
    #1;
    check("abort state", bus.state_num, 0);
    check("abort ready", bus.ready_out, 1);
    check("abort histogram", bus.histogram_out, 0);
    check("abort strobe", bus.x_read_addr_valid, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    vcnt = 0;
    repeat (40) begin
      @(negedge clk_in);
      if (bus.valid_out === 1'b1) vcnt++;
    end
    check("abort no valid_out", vcnt, 0);
    fill(0, 0);
    for (int p = 0; p < 8; p++) put(3 + p % 5, 3 + p / 5, sb_gx[p], sb_gy[p]);
    run(5, 5, "post-reset");
    for (int k = 0; k < 8; k++)
      check($sformatf("post-reset hand bin%0d", k), hist_bin(k), weight(sb_gx[k], sb_gy[k]));

    // Random fields biased toward extremes, ties and zeros.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NPIX; i++) begin
        case ($urandom_range(0, 7))
          0: gx_mem[i] = 0;
          1: gx_mem[i] = -128;
          2: gx_mem[i] = 127;
          3: gx_mem[i] = 4;
          4: gx_mem[i] = -4;
          default: gx_mem[i] = int'($urandom_range(0, 255)) - 128;
        endcase
        case ($urandom_range(0, 5))
          0: gy_mem[i] = 0;
          1: gy_mem[i] = -128;
          2: gy_mem[i] = 4;
          3: gy_mem[i] = -4;
          default: gy_mem[i] = int'($urandom_range(0, 255)) - 128;
        endcase
      end
      cx = int'($urandom_range(0, 63));
      cy = int'($urandom_range(0, 63));
      run(cx, cy, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/orientation_histogram.md
Name: orientation_histogram

Overview:
Successor to the single-pixel orientation classifier. Given a keypoint centre, it scans a parametrised (2R+1)x(2R+1) window of the X and Y gradient BRAMs in parallel, one pixel per cycle. Each pixel is classified into one of 8 octant bins and accumulated into a histogram. It reports the full histogram plus the dominant bin. Sits between the keypoint detector and descriptor generation.

Parameters:
WIDTH, 64, image width in pixels
HEIGHT, 64, image height in pixels
BIT_DEPTH, 8, gradient word width, signed two's complement
RADIUS, 2, window half-size; window side W=2*RADIUS+1
CNT_W, derived, counter width: $clog2(W*W+1), plus BIT_DEPTH+1 when MAG_WEIGHT_EN is defined

Ports:
clk_in  in  1  clock
rst_n_in  in  1  reset
center_x_in  in  $clog2(WIDTH)  keypoint column
center_y_in  in  $clog2(HEIGHT)  keypoint row
valid_in  in  1  request strobe; accepted only when ready_out=1
ready_out  out  1  high in IDLE only
x_read_addr  out  $clog2(WIDTH*HEIGHT)  X-gradient BRAM address
x_read_addr_valid  out  1  X read strobe
x_pixel_in  in  BIT_DEPTH  X-gradient data, 2-cycle read latency
y_read_addr  out  $clog2(WIDTH*HEIGHT)  Y-gradient BRAM address, always equals x_read_addr
y_read_addr_valid  out  1  Y read strobe, always equals x_read_addr_valid
y_pixel_in  in  BIT_DEPTH  Y-gradient data, 2-cycle read latency
valid_out  out  1  one-cycle pulse when outputs are valid
histogram_out  out  8*CNT_W  bin k occupies bits [k*CNT_W +: CNT_W]
dominant_bin_out  out  3  index of the largest bin
dominant_count_out  out  CNT_W  value of the largest bin
state_num  out  3  current state encoding, for debug

Behaviour:
- Single clock clk_in. Reset rst_n_in is asynchronous, active-low.
- Reset values: all outputs 0 except ready_out=1; histogram cleared; state IDLE. An asserted reset mid-operation aborts immediately, returns to IDLE, and produces no valid_out.
- States and transitions (state_num encoding in brackets):
  - IDLE(0): on valid_in, latch centre, clear all 8 bins, set row/col offsets to -R, go to SCAN. valid_in outside IDLE is ignored.
  - SCAN(1): one window position per cycle, raster order, column fastest.
    - In-bounds positions (0<=x<WIDTH, 0<=y<HEIGHT) issue address x+y*WIDTH with strobe high.
    - Out-of-bounds positions are clipped: strobe low, no read issued, still one cycle each.
    - After the W*W-th position, go to DRAIN.
  - DRAIN(2): wait 2 cycles for in-flight reads to return, then go to FIND.
  - FIND(3): 8 cycles, compare bins 0..7 in turn. A strictly greater value replaces the current maximum, so ties resolve to the lowest index. Then go to DONE.
  - DONE(4): valid_out=1 for one cycle, then return to IDLE.
- Outputs hold their values until the next accept.
- Total latency from accept to valid_out: 1+W*W+2+8 cycles; 36 for R=2.
- Read pipeline:
  - A 2-stage shift of the strobe tags returning data; accumulation happens when the tag arrives.
  - Each accumulated pixel increments exactly one bin.
  - Counters saturate at 2^CNT_W-1.
- Classification. Let ax=|gx| and ay=|gy|, computed as unsigned BIT_DEPTH-bit values, so -2^(B-1) maps to 2^(B-1).
  - gx>=0, gy>=0: bin 0 if ax>=ay, else bin 1.
  - gx<0, gy>=0: bin 2 if ay>ax, else bin 3.
  - gx<0, gy<0: bin 4 if ax>=ay, else bin 5.
  - gx>=0, gy<0: bin 6 if ay>ax, else bin 7.
  - gx=gy=0: no bin incremented (no orientation).
- If every bin is 0: dominant_bin_out=0, dominant_count_out=0.

Optional Feature:
MAG_WEIGHT_EN:
- Defined: each pixel adds ax+ay, a (BIT_DEPTH+1)-bit value, to its bin instead of 1; CNT_W widened as in Parameters.
- Undefined: unit increments.
- Classification, clipping and latency are identical in both builds.

Decomposition:
- Shared package sift_pkg: state enum, NUM_BINS=8, bin index typedef, CNT_W function.
- One sub-module, octant_classifier: purely combinational; gx, gy in; bin index, zero flag and magnitude out.
- Histogram RAM, FSM and dominant search stay in the top-level module.

Test Plan:
1. Uniform field gx=+10, gy=+3, centre (32,32), R=2 -> bin0=25, all other bins 0, dominant 0/25, valid_out exactly 36 cycles after accept.
2. Corner centre (0,0), gx=-5, gy=+9 -> 9 reads issued, bin2=9, other 16 window positions issue no strobe.
3. Octant sweep: fill each of 8 pixels with one (gx,gy) per bin, including ties (4,4)->0, (-4,4)->3, (-128,0)->3, and zeros elsewhere -> each bin=1, zero pixels uncounted.
4. Tie: bins 3 and 6 both reach 5 with all others lower -> dominant_bin_out=3.
5. rst_n_in low mid-SCAN, then a new request -> no valid_out from the aborted run; the new result is correct with histogram cleared.
6. With MAG_WEIGHT_EN defined: window of gx=-3, gy=-7 -> bin5=25*10=250, dominant 5.
